// File: rtl/iq16qam_pkg.sv
// Shared constants for the 16QAM mapper/demapper pair: amplitude, nibble bit
// positions, word packing geometry and the Gray level table.
package iq16qam_pkg;

  localparam int LVL_DEF = 1;
  localparam int W_DEF   = 11;
  localparam int NSYM    = 32;
  localparam int WORD_W  = 4 * NSYM;
  localparam int NSYM_W  = 6;

  localparam int R_MSB = 0;
  localparam int I_MSB = 1;
  localparam int R_LSB = 2;
  localparam int I_LSB = 3;

  // Level in units of LVL, indexed by {msb,lsb}: 00=+3, 01=+1, 10=-3, 11=-1
  localparam int GRAY_LVL [4] = '{3, 1, -3, -1};

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PEND = 1'b1
  } acc_state_e;

endpackage

// File: rtl/iqdemap_16qam_if.sv
// Packed-word bus from the demapper to the downstream writer.
// valid/ready: a word transfers on a rising edge where writer_valid and
// writer_ready are both high; writer_data/writer_nsym hold while valid waits.
interface iqdemap_16qam_if;
  import iq16qam_pkg::*;

  logic [WORD_W-1:0] writer_data;
  logic              writer_valid;
  logic              writer_ready;
  logic [NSYM_W-1:0] writer_nsym;

  modport master (
    output writer_data,
    output writer_valid,
    output writer_nsym,
    input  writer_ready
  );

  modport slave (
    input  writer_data,
    input  writer_valid,
    input  writer_nsym,
    output writer_ready
  );

endinterface

// File: rtl/qam16_slicer.sv
// One-axis hard slicer: sign gives the Gray msb, inner/outer ring gives the lsb.
module qam16_slicer
  import iq16qam_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int LVL = LVL_DEF
) (
  input  logic signed [W-1:0] x_i,
  output logic                msb_o,
  output logic                lsb_o
);

  localparam logic [W:0] THR = (W+1)'(2 * LVL);

  logic [W:0] mag;

  // One extra bit so the most negative sample maps to a positive magnitude
  always_comb begin
    mag   = x_i[W-1] ? (~{x_i[W-1], x_i} + 1'b1) : {x_i[W-1], x_i};
    msb_o = x_i[W-1];
    lsb_o = (mag < THR);
  end

endmodule

// File: rtl/iqdemap_16qam.sv
// 16QAM hard demapper: slices I/Q to Gray nibbles and packs 32 of them into a
// 128-bit word, with flush for partial words and full backpressure support.
module iqdemap_16qam
  import iq16qam_pkg::*;
#(
  parameter int LVL = LVL_DEF,
  parameter int W   = W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ce,
  input  logic                valid_i,
  input  logic signed [W-1:0] xr,
  input  logic signed [W-1:0] xi,
  input  logic                flush,
  output logic                ready_o,
  iqdemap_16qam_if.master     wr_if,
  output logic [3:0]          raw,
  output logic                valid_raw,
  output acc_state_e          dbg_state_o
);

  logic r_msb, r_lsb, i_msb, i_lsb;
  logic [3:0] nib;

  qam16_slicer #(.W(W), .LVL(LVL)) u_slice_r (.x_i(xr), .msb_o(r_msb), .lsb_o(r_lsb));
  qam16_slicer #(.W(W), .LVL(LVL)) u_slice_i (.x_i(xi), .msb_o(i_msb), .lsb_o(i_lsb));

  acc_state_e        state_q, state_d;
  logic [NSYM_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [NSYM_W-1:0] wnsym_q, wnsym_d;
  logic              wvalid_q, wvalid_d;
  logic [3:0]        raw_q, raw_d;
  logic              vraw_q, vraw_d;
  logic              xfer, accept;

  always_comb begin
    nib        = '0;
    nib[R_MSB] = r_msb;
    nib[I_MSB] = i_msb;
    nib[R_LSB] = r_lsb;
    nib[I_LSB] = i_lsb;
  end

  // A pending word moves out when the output register is free or being emptied
  assign xfer    = (state_q == ST_PEND) && (!wvalid_q || wr_if.writer_ready);
  assign ready_o = (state_q == ST_FILL) || xfer;
  assign accept  = ce && valid_i && ready_o;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    wdata_d  = wdata_q;
    wnsym_d  = wnsym_q;
    wvalid_d = wvalid_q;
    raw_d    = raw_q;
    vraw_d   = accept;

    if (accept) raw_d = nib;
    if (wr_if.writer_ready) wvalid_d = 1'b0;

    if (xfer) begin
      wdata_d  = acc_q;
      wnsym_d  = cnt_q;
      wvalid_d = 1'b1;
      acc_d    = '0;
      cnt_d    = '0;
    end

    // A symbol accepted during a transfer lands in nibble 0 of the fresh word
    if (accept) begin
      acc_d[4*cnt_d[4:0] +: 4] = nib;
      cnt_d                    = cnt_d + 1'b1;
    end

    if ((cnt_d == NSYM_W'(NSYM)) || (flush && (cnt_d != '0)) ||
        ((state_q == ST_PEND) && !xfer))
      state_d = ST_PEND;
    else
      state_d = ST_FILL;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= ST_FILL;
      cnt_q    <= '0;
      acc_q    <= '0;
      wdata_q  <= '0;
      wnsym_q  <= '0;
      wvalid_q <= 1'b0;
      raw_q    <= '0;
      vraw_q   <= 1'b0;
    end else if (ce) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wdata_q  <= wdata_d;
      wnsym_q  <= wnsym_d;
      wvalid_q <= wvalid_d;
      raw_q    <= raw_d;
      vraw_q   <= vraw_d;
    end
  end

  assign wr_if.writer_data  = wdata_q;
  assign wr_if.writer_valid = wvalid_q;
  assign wr_if.writer_nsym  = wnsym_q;
  assign raw                = raw_q;
  assign valid_raw          = vraw_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_iqdemap_16qam.sv
// Bench for iqdemap_16qam: threshold table, directed word/flush/backpressure/reset
// sequences and a randomized run against a decision-region reference model.
module tb_iqdemap_16qam;
  import iq16qam_pkg::*;

  localparam int W   = 11;
  localparam int LVL = 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                ce = 1'b1;
  logic                valid_i = 1'b0;
  logic                flush = 1'b0;
  logic signed [W-1:0] xr = '0;
  logic signed [W-1:0] xi = '0;
  logic                ready_o;
  logic [3:0]          raw;
  logic                valid_raw;
  acc_state_e          dbg_state;

  iqdemap_16qam_if wif ();

  iqdemap_16qam #(.LVL(LVL), .W(W)) dut (
    .CLK         (clk),
    .RST         (rst_n),
    .ce          (ce),
    .valid_i     (valid_i),
    .xr          (xr),
    .xi          (xi),
    .flush       (flush),
    .ready_o     (ready_o),
    .wr_if       (wif),
    .raw         (raw),
    .valid_raw   (valid_raw),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // ---------------- reference model ----------------
  // Nearest constellation level on one axis, then its Gray code {msb,lsb}
  function automatic logic [1:0] ref_axis(input int x);
    int lev;
    if (x >= 2*LVL)     lev = 3;
    else if (x >= 0)    lev = 1;
    else if (x > -2*LVL) lev = -1;
    else                lev = -3;
    case (lev)
      3:       return 2'b00;
      1:       return 2'b01;
      -1:      return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [3:0] ref_nib(input int r, input int i);
    logic [1:0] rb, ib;
    rb = ref_axis(r);
    ib = ref_axis(i);
    return {ib[0], rb[0], ib[1], rb[1]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [3:0]   cur_q[$];
  logic [127:0] exp_q[$];
  logic [5:0]   exp_n_q[$];
  logic [3:0]   raw_q[$];
  int           n_acc = 0;
  int           n_words = 0;
  logic [127:0] last_word = '0;
  logic [5:0]   last_nsym = '0;
  logic         last_ce = 1'b0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = '0;
  logic [5:0]   prev_nsym = '0;
  logic [3:0]   m_nib;
  logic [127:0] m_word;

  always @(negedge clk) begin
    if (last_ce && valid_raw) begin
      if (raw_q.size() == 0) fail_now("raw_unexpected");
      else check("raw", raw, raw_q.pop_front());
    end
    if (prev_stall && wif.writer_valid) begin
      check("hold_data", wif.writer_data, prev_data);
      check("hold_nsym", wif.writer_nsym, prev_nsym);
    end

    if (!rst_n) begin
      cur_q.delete();
      exp_q.delete();
      exp_n_q.delete();
      raw_q.delete();
    end else if (ce) begin
      if (wif.writer_valid && wif.writer_ready) begin
        if (exp_q.size() == 0) fail_now("word_unexpected");
        else begin
          check("word_data", wif.writer_data, exp_q.pop_front());
          check("word_nsym", wif.writer_nsym, exp_n_q.pop_front());
        end
        last_word = wif.writer_data;
        last_nsym = wif.writer_nsym;
        n_words++;
      end
      if (valid_i && ready_o) begin
        m_nib = ref_nib(int'(xr), int'(xi));
        cur_q.push_back(m_nib);
        raw_q.push_back(m_nib);
        n_acc++;
      end
      if (cur_q.size() == NSYM || (flush && cur_q.size() > 0)) begin
        m_word = '0;
        for (int k = 0; k < cur_q.size(); k++) m_word[4*k +: 4] = cur_q[k];
        exp_q.push_back(m_word);
        exp_n_q.push_back(6'(cur_q.size()));
        cur_q.delete();
      end
    end

    prev_stall = rst_n && wif.writer_valid && !(ce && wif.writer_ready);
    prev_data  = wif.writer_data;
    prev_nsym  = wif.writer_nsym;
    last_ce    = ce && rst_n;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    flush   = 1'b0;
    repeat (n) tick();
  endtask

  // Presents one symbol and returns one cycle after it has been accepted
  task automatic send(input int r, input int i);
    int t;
    t = 0;
    xr = W'(r);
    xi = W'(i);
    valid_i = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!(ce && ready_o) && t < 300);
    if (t >= 300) fail_now("send_timeout");
    tick();
  endtask

  task automatic pulse_flush();
    valid_i = 1'b0;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  wif.writer_data, '0);
    check({tag, "_valid"}, wif.writer_valid, 1'b0);
    check({tag, "_nsym"},  wif.writer_nsym, '0);
    check({tag, "_raw"},   raw, '0);
    check({tag, "_vraw"},  valid_raw, 1'b0);
    check({tag, "_ready"}, ready_o, 1'b1);
    check({tag, "_state"}, dbg_state, ST_FILL);
  endtask

  // ---------------- threshold table ----------------
  typedef struct {
    int         r;
    int         i;
    logic [3:0] exp_raw;
  } vec_t;

  vec_t tv[9];
  logic [127:0] k_word;
  int a0, w0;

  initial begin
    tv[0] = '{2, 2, 4'b0000};
    tv[1] = '{1, 1, 4'b1100};
    tv[2] = '{0, 0, 4'b1100};
    tv[3] = '{-1, -1, 4'b1111};
    tv[4] = '{-2, -2, 4'b0011};
    tv[5] = '{-1024, -1024, 4'b0011};
    tv[6] = '{1023, 1023, 4'b0000};
    tv[7] = '{1, -3, 4'b0110};
    tv[8] = '{-2, 1, 4'b1001};

    wif.writer_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Full word of +3/+3 and accept-to-valid latency
    for (int k = 0; k < 32; k++) send(3, 3);
    valid_i = 1'b0;
    @(negedge clk);
    check("lat_early", wif.writer_valid, 1'b0);
    @(negedge clk);
    check("lat_valid", wif.writer_valid, 1'b1);
    check("w33_data", wif.writer_data, '0);
    check("w33_nsym", wif.writer_nsym, 6'd32);
    tick();
    idle(2);

    for (int k = 0; k < 32; k++) send(-1, 1);
    idle(4);
    k_word = {32{4'hD}};
    check("wD_data", last_word, k_word);
    check("wD_nsym", last_nsym, 6'd32);

    for (int k = 0; k < 32; k++) send(-3, -3);
    idle(4);
    k_word = {32{4'h3}};
    check("w3_data", last_word, k_word);

    // Thresholds, one symbol at a time
    for (int k = 0; k < 9; k++) begin
      send(tv[k].r, tv[k].i);
      valid_i = 1'b0;
      @(negedge clk);
      check("thr_vraw", valid_raw, 1'b1);
      check("thr_raw", raw, tv[k].exp_raw);
      tick();
    end
    pulse_flush();
    idle(4);
    check("thr_nsym", last_nsym, 6'd9);

    // Partial word by flush
    for (int k = 0; k < 5; k++) send(1, -3);
    pulse_flush();
    idle(4);
    check("fl5_nsym", last_nsym, 6'd5);
    check("fl5_data", last_word, 128'h66666);

    // Flush coincident with the last accepted symbol
    send(3, -1);
    send(3, -1);
    flush = 1'b1;
    send(-3, 3);
    flush = 1'b0;
    idle(4);
    check("flc_nsym", last_nsym, 6'd3);
    check("flc_data", last_word, 128'h1AA);

    // Flush with nothing pending
    w0 = n_words;
    pulse_flush();
    idle(4);
    check("fl0_words", n_words, w0);

    // Clock enable low freezes everything
    ce = 1'b0;
    xr = 1;
    xi = 1;
    valid_i = 1'b1;
    repeat (5) tick();
    valid_i = 1'b0;
    ce = 1'b1;
    send(1, 1);
    pulse_flush();
    idle(4);
    check("ce_nsym", last_nsym, 6'd1);

    // Backpressure: two words queue up, input stalls
    wif.writer_ready = 1'b0;
    a0 = n_acc;
    repeat (70) begin
      xr = W'($urandom_range(2047));
      xi = W'($urandom_range(2047));
      valid_i = 1'b1;
      tick();
    end
    valid_i = 1'b0;
    @(negedge clk);
    check("bp_ready", ready_o, 1'b0);
    check("bp_valid", wif.writer_valid, 1'b1);
    check("bp_state", dbg_state, ST_PEND);
    check("bp_accepted", n_acc - a0, 64);
    tick();
    wif.writer_ready = 1'b1;
    idle(6);
    check("bp_ready_back", ready_o, 1'b1);
    check("bp_drained", exp_q.size(), 0);

    // Reset mid-word discards it
    for (int k = 0; k < 10; k++) send(int'($urandom_range(2047)) - 1024, 3);
    valid_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) send(-1, -1);
    idle(4);
    k_word = {32{4'hF}};
    check("rst_clean_data", last_word, k_word);
    check("rst_clean_nsym", last_nsym, 6'd32);

    // Randomized traffic with random ce, backpressure and flushes
    repeat (600) begin
      ce               = ($urandom_range(9) != 0);
      valid_i          = ($urandom_range(9) < 7);
      wif.writer_ready = ($urandom_range(9) < 6);
      flush            = ($urandom_range(19) == 0);
      xr               = W'($urandom_range(2047));
      xi               = W'($urandom_range(2047));
      tick();
    end
    ce = 1'b1;
    wif.writer_ready = 1'b1;
    idle(3);
    pulse_flush();
    idle(10);
    check("final_words_left", exp_q.size(), 0);
    check("final_syms_left", cur_q.size(), 0);
    check("final_raw_left", raw_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
